ysyx_22040365_idu: RTL and testbench
====================================

# ysyx_22040365_idu

Pipelined, parametrised instruction decode unit for the NPC core. It sits between the IFU and the EXU, accepts one 32-bit RV64I instruction per cycle over a valid/ready handshake, and presents a registered decode bundle to the EXU. Compared with the single-cycle ADDI-only decoder it:
- decodes the full RV64I base set, with optional W-ops;
- generates all five immediate formats;
- flags illegal encodings;
- absorbs EXU back-pressure through a two-entry skid buffer, keeping full throughput.

## Interface
Parameters:
- XLEN, 64: datapath width; immediates are sign-extended to XLEN.
- EN_W, 1: when 1, OP-IMM-32/OP-32 decode as legal; when 0 they decode as illegal.
- TYPE_W, 4: width of the op-class code.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  drop all held instructions (redirect from EXU)
- in_valid  in  1  IFU offers an instruction
- in_ready  out  1  IDU can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of in_inst
- out_valid  out  1  decode bundle valid
- out_ready  in  1  EXU accepts bundle
- out_pc  out  XLEN  PC passthrough
- out_type  out  TYPE_W  op class; values live in the shared defines package
- out_func3  out  3  inst[14:12]
- out_func7b5  out  1  inst[30]
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate (zero when the format has none)
- out_ren_rs1, out_ren_rs2, out_wen_rd  out  1 each  register-file enables
- out_illegal  out  1  unrecognised encoding

## Operation
- Op classes: ALU_I, ALU_R, ALU_IW, ALU_RW, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, EBREAK, ECALL, ILLEGAL.
- Classification uses opcode[6:2], func3 and func7.
- Legality checks:
  - opcode[1:0] != 2'b11 → ILLEGAL.
  - Shift immediates: inst[31:26] must be 0 or 010000; shamt width is 6 for XLEN=64, 5 for W-ops.
- Immediate generation:
  - I: {inst[31:20]}
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}
  - All are sign-extended from bit 31 to XLEN.
- Enables:
  - ren_rs1 for all classes except LUI/AUIPC/JAL/EBREAK/ECALL/ILLEGAL.
  - ren_rs2 for ALU_R, ALU_RW, STORE, BRANCH.
  - wen_rd for all writers, forced to 0 when rd==0 or the instruction is illegal.
- Illegal instructions still flow downstream with out_illegal=1 and all enables cleared.
- Storage is a main output register plus one skid register:
  - in_ready = ~skid_valid.
  - Transfer on the input side when in_valid&in_ready; on the output side when out_valid&out_ready.
  - Accept while output empty or draining → decode into the output register.
  - Accept while output held → decode into skid.
  - Output drains while skid full → skid moves to output.

## Timing
- Latency: one cycle from input transfer to out_valid.
- Throughput: one instruction per cycle while out_ready=1.
- While rst_n=0 at an edge: out_valid=0, skid_valid=0, all out_* bundle fields=0, in_ready=0 combinationally during reset. First cycle after reset: in_ready=1.
- Reset asserted mid-transfer discards both entries; no partial bundle is ever presented.
- flush=1 at an edge: out_valid and skid_valid cleared next cycle; the simultaneous input transfer is dropped; flush has priority over accept.
- While out_valid=1 and out_ready=0, every out_* field stays stable.
- Skid full + out_ready=1 + in_valid: skid moves to output; the input is not accepted (in_ready was 0 that cycle).
- No combinational path from out_ready to in_ready.

## Structure
- Op-class codes, opcode constants (OP_IMM, OP, LUI, ...) and TYPE_W go in ysyx_22040365_defines.v.
- Sub-module ysyx_22040365_idu_dec: purely combinational, inst → bundle. Instantiated once on in_inst; its result is registered into output or skid.
- Top level holds only the handshake/skid control and registers.

## Test plan
- 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle ALU_I, rd=1, rs1=0, imm=5, ren_rs1=1, wen_rd=1.
- 0x12345137 (lui x2) → LUI, imm=0x0000000012345000, ren_rs1=0, wen_rd=1. 0xFE000EE3 (beq x0,x0,-4) → BRANCH, imm=0xFFFFFFFFFFFFFFFC, ren_rs2=1, wen_rd=0.
- 0x00000000 → out_illegal=1, all enables 0. 0x00100073 → EBREAK. 0x0000009B (addiw x1) with EN_W=0 → illegal.
- Stream 4 instructions, hold out_ready=0 for 3 cycles starting cycle 2:
  - in_ready drops after the skid fills;
  - no loss or duplication;
  - PCs exit in order once out_ready=1.
- Skid full, then flush=1 together with in_valid=1 → next cycle out_valid=0, skid empty, in_ready=1; the flushed PCs never appear.
- rst_n=0 for one cycle while out_valid=1 and skid full → out_valid=0 next cycle; first post-reset instruction decodes with normal one-cycle latency.

Source files
------------

// File: rtl/ysyx_22040365_idu_pkg.sv
// Shared decode definitions for the NPC IDU: op-class codes, RV64I major
// opcodes (inst[6:2]), immediate formats and the decoded control bundle.
package ysyx_22040365_idu_pkg;

  localparam int OP_TYPE_W = 4;

  typedef enum logic [OP_TYPE_W-1:0] {
    T_ALU_I   = 4'd0,
    T_ALU_R   = 4'd1,
    T_ALU_IW  = 4'd2,
    T_ALU_RW  = 4'd3,
    T_LOAD    = 4'd4,
    T_STORE   = 4'd5,
    T_BRANCH  = 4'd6,
    T_LUI     = 4'd7,
    T_AUIPC   = 4'd8,
    T_JAL     = 4'd9,
    T_JALR    = 4'd10,
    T_EBREAK  = 4'd11,
    T_ECALL   = 4'd12,
    T_ILLEGAL = 4'd13
  } op_type_e;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    op_type_e   op_type;
    logic [2:0] func3;
    logic       func7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       ren_rs1;
    logic       ren_rs2;
    logic       wen_rd;
    logic       illegal;
  } dec_ctl_t;

endpackage

// File: rtl/ysyx_22040365_idu_dec.sv
// Combinational RV64I decoder: instruction word -> control bundle + immediate.
// FENCE/CSR encodings have no op class here and therefore decode as illegal.
module ysyx_22040365_idu_dec
  import ysyx_22040365_idu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit EN_W = 1'b1
) (
  input  logic [31:0]     inst_i,
  output dec_ctl_t        ctl_o,
  output logic [XLEN-1:0] imm_o
);

  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        ok;
  logic        shamt_ok;
  op_type_e    cls;
  imm_fmt_e    fmt;
  logic [31:0] imm32;

  assign opc = inst_i[6:2];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  // 6-bit shamt on RV64 lets inst[25] carry shamt[5]; RV32 must keep it clear
  assign shamt_ok = (inst_i[31:26] == 6'b000000 || inst_i[31:26] == 6'b010000) &&
                    ((XLEN == 64) || !inst_i[25]);

  always_comb begin
    ok  = 1'b0;
    cls = T_ILLEGAL;
    fmt = IMM_NONE;
    if (inst_i[1:0] == 2'b11) begin
      case (opc)
        OPC_LOAD:      begin ok = (f3 != 3'b111);       cls = T_LOAD;   fmt = IMM_I; end
        OPC_STORE:     begin ok = !f3[2];               cls = T_STORE;  fmt = IMM_S; end
        OPC_BRANCH:    begin ok = (f3[2:1] != 2'b01);   cls = T_BRANCH; fmt = IMM_B; end
        OPC_OP_IMM:    begin ok = (f3[1:0] != 2'b01) || shamt_ok; cls = T_ALU_I; fmt = IMM_I; end
        OPC_OP_IMM_32: begin
          ok  = EN_W && ((f3 == 3'b000) ||
                         (f3 == 3'b001 && f7 == 7'h00) ||
                         (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)));
          cls = T_ALU_IW;
          fmt = IMM_I;
        end
        OPC_OP:        begin
          ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
          cls = T_ALU_R;
        end
        OPC_OP_32:     begin
          ok  = EN_W && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101) &&
                ((f7 == 7'h00) || (f7 == 7'h20 && f3 != 3'b001));
          cls = T_ALU_RW;
        end
        OPC_LUI:       begin ok = 1'b1; cls = T_LUI;   fmt = IMM_U; end
        OPC_AUIPC:     begin ok = 1'b1; cls = T_AUIPC; fmt = IMM_U; end
        OPC_JAL:       begin ok = 1'b1; cls = T_JAL;   fmt = IMM_J; end
        OPC_JALR:      begin ok = (f3 == 3'b000); cls = T_JALR; fmt = IMM_I; end
        OPC_SYSTEM:    begin
          if (inst_i == INST_EBREAK) begin
            ok  = 1'b1;
            cls = T_EBREAK;
          end else if (inst_i == INST_ECALL) begin
            ok  = 1'b1;
            cls = T_ECALL;
          end
        end
        default: ;
      endcase
    end
    if (!ok) begin
      cls = T_ILLEGAL;
      fmt = IMM_NONE;
    end
  end

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U: imm32 = {inst_i[31:12], 12'd0};
      IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

  always_comb begin
    ctl_o         = '0;
    ctl_o.op_type = cls;
    ctl_o.func3   = f3;
    ctl_o.func7b5 = inst_i[30];
    ctl_o.rs1     = inst_i[19:15];
    ctl_o.rs2     = inst_i[24:20];
    ctl_o.rd      = inst_i[11:7];
    ctl_o.illegal = (cls == T_ILLEGAL);
    ctl_o.ren_rs1 = !(cls inside {T_LUI, T_AUIPC, T_JAL, T_EBREAK, T_ECALL, T_ILLEGAL});
    ctl_o.ren_rs2 = (cls inside {T_ALU_R, T_ALU_RW, T_STORE, T_BRANCH});
    ctl_o.wen_rd  = !(cls inside {T_STORE, T_BRANCH, T_EBREAK, T_ECALL, T_ILLEGAL}) &&
                    (inst_i[11:7] != 5'd0);
  end

endmodule

// File: rtl/ysyx_22040365_idu.sv
// Pipelined IDU: decodes in_inst and registers the bundle into an output
// register backed by a one-entry skid so EXU stalls never cost throughput.
module ysyx_22040365_idu
  import ysyx_22040365_idu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit EN_W   = 1'b1,
  parameter int TYPE_W = OP_TYPE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [TYPE_W-1:0] out_type,
  output logic [2:0]        out_func3,
  output logic              out_func7b5,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_ren_rs1,
  output logic              out_ren_rs2,
  output logic              out_wen_rd,
  output logic              out_illegal
);

  dec_ctl_t        dec_ctl;
  logic [XLEN-1:0] dec_imm;

  ysyx_22040365_idu_dec #(.XLEN(XLEN), .EN_W(EN_W)) u_dec (
    .inst_i (in_inst),
    .ctl_o  (dec_ctl),
    .imm_o  (dec_imm)
  );

  logic            out_vld_q, out_vld_d;
  dec_ctl_t        out_ctl_q, out_ctl_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [XLEN-1:0] out_pc_q,  out_pc_d;
  logic            skid_vld_q, skid_vld_d;
  dec_ctl_t        skid_ctl_q, skid_ctl_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [XLEN-1:0] skid_pc_q,  skid_pc_d;
  logic            accept;

  // depends only on registered state and reset, never on out_ready
  assign in_ready = rst_n & ~skid_vld_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_ctl_d  = out_ctl_q;
    out_imm_d  = out_imm_q;
    out_pc_d   = out_pc_q;
    skid_vld_d = skid_vld_q;
    skid_ctl_d = skid_ctl_q;
    skid_imm_d = skid_imm_q;
    skid_pc_d  = skid_pc_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // skid full implies output full and no accept this cycle
      if (out_ready) begin
        out_ctl_d  = skid_ctl_q;
        out_imm_d  = skid_imm_q;
        out_pc_d   = skid_pc_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept && (!out_vld_q || out_ready)) begin
      out_vld_d = 1'b1;
      out_ctl_d = dec_ctl;
      out_imm_d = dec_imm;
      out_pc_d  = in_pc;
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_ctl_d = dec_ctl;
      skid_imm_d = dec_imm;
      skid_pc_d  = in_pc;
    end else if (out_vld_q && out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_ctl_q  <= '0;
      out_imm_q  <= '0;
      out_pc_q   <= '0;
      skid_vld_q <= 1'b0;
      skid_ctl_q <= '0;
      skid_imm_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_ctl_q  <= out_ctl_d;
      out_imm_q  <= out_imm_d;
      out_pc_q   <= out_pc_d;
      skid_vld_q <= skid_vld_d;
      skid_ctl_q <= skid_ctl_d;
      skid_imm_q <= skid_imm_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign out_pc      = out_pc_q;
  assign out_type    = TYPE_W'(out_ctl_q.op_type);
  assign out_func3   = out_ctl_q.func3;
  assign out_func7b5 = out_ctl_q.func7b5;
  assign out_rs1     = out_ctl_q.rs1;
  assign out_rs2     = out_ctl_q.rs2;
  assign out_rd      = out_ctl_q.rd;
  assign out_imm     = out_imm_q;
  assign out_ren_rs1 = out_ctl_q.ren_rs1;
  assign out_ren_rs2 = out_ctl_q.ren_rs2;
  assign out_wen_rd  = out_ctl_q.wen_rd;
  assign out_illegal = out_ctl_q.illegal;

endmodule

// File: tb/tb_ysyx_22040365_idu.sv
// Bench for the IDU: queue-based occupancy model plus an instruction-level
// decode model, checked every cycle on an EN_W=1 and an EN_W=0 instance.
module tb_ysyx_22040365_idu;
  import ysyx_22040365_idu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = 32'd0;
  logic [63:0] in_pc = 64'd0;

  logic        a_in_ready, a_out_valid, a_f7b5, a_r1, a_r2, a_w, a_ill;
  logic [63:0] a_pc, a_imm;
  logic [3:0]  a_type;
  logic [2:0]  a_f3;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic        b_in_ready, b_out_valid, b_f7b5, b_r1, b_r2, b_w, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [3:0]  b_type;
  logic [2:0]  b_f3;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  always #5 clk = ~clk;

  ysyx_22040365_idu #(.XLEN(64), .EN_W(1'b1), .TYPE_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_type(a_type), .out_func3(a_f3), .out_func7b5(a_f7b5),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
    .out_ren_rs1(a_r1), .out_ren_rs2(a_r2), .out_wen_rd(a_w), .out_illegal(a_ill));

  ysyx_22040365_idu #(.XLEN(64), .EN_W(1'b0), .TYPE_W(4)) u_dut_nw (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_type(b_type), .out_func3(b_f3), .out_func7b5(b_f7b5),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
    .out_ren_rs1(b_r1), .out_ren_rs2(b_r2), .out_wen_rd(b_w), .out_illegal(b_ill));

  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  typedef struct packed {
    logic [3:0] ty; logic [2:0] f3; logic f7b5; logic [4:0] rs1, rs2, rd;
    logic [63:0] imm; logic r1, r2, w, ill;
  } exp_t;

  ent_t        q[$];
  logic [63:0] outlog[$];
  int          n_cmp = 0, n_err = 0;
  bit          saw_ir_low;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Decode straight from the ISA tables, one opcode at a time.
  function automatic exp_t model(input bit en_w, input logic [31:0] i);
    exp_t e;
    op_type_e c;
    bit ok;
    byte fmt;
    longint v;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    ok = 1'b1; fmt = "N"; c = T_ILLEGAL;
    case (op)
      7'h03: begin c = T_LOAD;   fmt = "I"; ok = (f3 != 7); end
      7'h23: begin c = T_STORE;  fmt = "S"; ok = (f3 < 4); end
      7'h63: begin c = T_BRANCH; fmt = "B"; ok = (f3 != 2 && f3 != 3); end
      7'h13: begin c = T_ALU_I;  fmt = "I";
        ok = !(f3 == 1 || f3 == 5) || (i[31:26] == 0 || i[31:26] == 6'd16); end
      7'h1b: begin c = T_ALU_IW; fmt = "I";
        ok = en_w && (f3 == 0 || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20))); end
      7'h33: begin c = T_ALU_R;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
      7'h3b: begin c = T_ALU_RW;
        ok = en_w && ((f7 == 0 && (f3 == 0 || f3 == 1 || f3 == 5)) ||
                      (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
      7'h37: begin c = T_LUI;   fmt = "U"; end
      7'h17: begin c = T_AUIPC; fmt = "U"; end
      7'h6f: begin c = T_JAL;   fmt = "J"; end
      7'h67: begin c = T_JALR;  fmt = "I"; ok = (f3 == 0); end
      7'h73: begin
        if (i == 32'h00100073) c = T_EBREAK;
        else if (i == 32'h00000073) c = T_ECALL;
        else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin c = T_ILLEGAL; fmt = "N"; end
    case (fmt)
      "I": v = $signed(i[31:20]);
      "S": v = $signed({i[31:25], i[11:7]});
      "B": v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      "U": v = $signed({i[31:12], 12'd0});
      "J": v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      default: v = 0;
    endcase
    e.imm = v;
    e.ty = c; e.f3 = f3; e.f7b5 = i[30]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.ill = (c == T_ILLEGAL);
    e.r1  = c inside {T_ALU_I, T_ALU_R, T_ALU_IW, T_ALU_RW, T_LOAD, T_STORE, T_BRANCH, T_JALR};
    e.r2  = c inside {T_ALU_R, T_ALU_RW, T_STORE, T_BRANCH};
    e.w   = !(c inside {T_STORE, T_BRANCH, T_EBREAK, T_ECALL, T_ILLEGAL}) && (i[11:7] != 0);
    return e;
  endfunction

  task automatic chk_bundle(input string tag, input exp_t e, input logic [3:0] ty,
                            input logic [63:0] imm, input logic [22:0] misc);
    chk({tag, "_type"}, 64'(ty), 64'(e.ty));
    chk({tag, "_imm"}, imm, e.imm);
    chk({tag, "_fields"}, 64'(misc), 64'({e.f3, e.f7b5, e.rs1, e.rs2, e.rd, e.r1, e.r2, e.w, e.ill}));
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic tick();
    bit exp_ir, exp_ov, acc, pop;
    #1;
    exp_ir = rst_n && (q.size() < 2);
    exp_ov = (q.size() > 0);
    chk("in_ready", 64'(a_in_ready), 64'(exp_ir));
    chk("out_valid", 64'(a_out_valid), 64'(exp_ov));
    chk("nw_out_valid", 64'(b_out_valid), 64'(exp_ov));
    if (!a_in_ready) saw_ir_low = 1'b1;
    if (exp_ov) begin
      chk("out_pc", a_pc, q[0].pc);
      chk_bundle("w1", model(1'b1, q[0].inst), a_type, a_imm,
                 {a_f3, a_f7b5, a_rs1, a_rs2, a_rd, a_r1, a_r2, a_w, a_ill});
      chk_bundle("w0", model(1'b0, q[0].inst), b_type, b_imm,
                 {b_f3, b_f7b5, b_rs1, b_rs2, b_rd, b_r1, b_r2, b_w, b_ill});
    end
    acc = in_valid && exp_ir;
    pop = exp_ov && out_ready;
    if (pop && rst_n && !flush) outlog.push_back(a_pc);
    @(posedge clk);
    if (!rst_n || flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{in_pc, in_inst});
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops[13] = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h1b, 7'h33, 7'h3b,
                            7'h37, 7'h17, 7'h6f, 7'h67, 7'h73, 7'h13};
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 15);
    if (k < 13) r[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 9) == 0) r = $urandom_range(0, 1) ? 32'h00100073 : 32'h00000073;
    return r;
  endfunction

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_pc", a_pc, 64'd0);
    chk("rst_imm", a_imm, 64'd0);
    chk("rst_type", 64'(a_type), 64'd0);
    chk("rst_en", 64'({a_r1, a_r2, a_w, a_ill}), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(32'h00500093, 64'h1000);
    chk("addi_type", 64'(a_type), 64'(T_ALU_I));
    chk("addi_regs", 64'({a_rd, a_rs1}), 64'({5'd1, 5'd0}));
    chk("addi_imm", a_imm, 64'd5);
    chk("addi_en", 64'({a_r1, a_w}), 64'b11);
    send(32'h12345137, 64'h1004);
    chk("lui_type", 64'(a_type), 64'(T_LUI));
    chk("lui_imm", a_imm, 64'h0000_0000_1234_5000);
    chk("lui_en", 64'({a_r1, a_w}), 64'b01);
    send(32'hFE000EE3, 64'h1008);
    chk("beq_type", 64'(a_type), 64'(T_BRANCH));
    chk("beq_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_en", 64'({a_r2, a_w}), 64'b10);
    send(32'h00000000, 64'h100C);
    chk("zero_ill", 64'({a_ill, a_r1, a_r2, a_w}), 64'b1000);
    send(32'h00100073, 64'h1010);
    chk("ebreak_type", 64'(a_type), 64'(T_EBREAK));
    send(32'h0000009B, 64'h1014);
    chk("addiw_w1", 64'({a_type, a_ill}), 64'({T_ALU_IW, 1'b0}));
    chk("addiw_w0", 64'({b_type, b_ill, b_w}), 64'({T_ILLEGAL, 1'b1, 1'b0}));
    tick();

    // 4-instruction stream with out_ready low on cycles 2..4
    outlog.delete(); saw_ir_low = 1'b0;
    begin
      int sent = 0;
      for (int c = 0; c < 12; c++) begin
        out_ready = !(c >= 2 && c <= 4);
        in_valid  = (sent < 4);
        in_inst   = 32'h00100013 | (32'(sent + 1) << 7);
        in_pc     = 64'h2000 + 64'(4 * sent);
        if (in_valid && q.size() < 2) sent++;
        tick();
      end
      in_valid = 1'b0;
    end
    chk("stream_backpressure", 64'(saw_ir_low), 64'd1);
    chk("stream_count", 64'(outlog.size()), 64'd4);
    for (int k = 0; k < 4 && k < outlog.size(); k++)
      chk("stream_order", outlog[k], 64'h2000 + 64'(4 * k));

    // fill output+skid, then flush with a simultaneous offer
    out_ready = 1'b0;
    send(32'h00500093, 64'h3000);
    send(32'h00600113, 64'h3004);
    chk("skid_full", 64'(a_in_ready), 64'd0);
    flush = 1'b1;
    send(32'h00700193, 64'h3008);
    flush = 1'b0;
    chk("flush_ov", 64'(a_out_valid), 64'd0);
    chk("flush_ir", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    tick(); tick();

    // reset while output and skid are both full
    out_ready = 1'b0;
    send(32'h00500093, 64'h4000);
    send(32'h00600113, 64'h4004);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_ov", 64'(a_out_valid), 64'd0);
    out_ready = 1'b1;
    send(32'h00800213, 64'h4100);
    chk("post_rst_ov", 64'(a_out_valid), 64'd1);
    chk("post_rst_pc", a_pc, 64'h4100);
    tick();

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = rnd_inst();
      in_pc     = {$urandom, $urandom} & ~64'd3;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
